axis_sample_pacer: RTL

- Upstream stage for the serial MAC FIR filters. A serial FIR filter needs about 19 clocks per sample and ignores backpressure.
- This block buffers bursty AXI-Stream samples in a small FIFO and releases them one beat at a time, spaced at least MIN_INTERVAL clocks apart.
- Burst sources (DMA, ADC packetizer) can then feed the filter without losing samples.
- The tlast bit travels with its sample.

---
 rtl/axis_sample_pacer_if.sv | 14 +
 rtl/axis_sample_pacer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/axis_sample_pacer_if.sv
// AXI-Stream bundle (tdata/tlast/tvalid/tready) shared by the pacer's
// input and output sides. The master drives payload and valid; the slave
// drives ready.
interface axis_sample_pacer_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_sample_pacer.sv
// axis_sample_pacer: buffers bursty AXI-Stream samples in a circular FIFO
// and releases them one registered beat at a time. Consecutive output
// beats are spaced so that the next tvalid rises no earlier than
// MIN_INTERVAL clocks after the previous output handshake.
// Optional macro PACER_RUNTIME_INTERVAL_EN adds a 16-bit 'interval' input
// that replaces MIN_INTERVAL; it is sampled at each output handshake and
// a value of 0 behaves as 1.
module axis_sample_pacer #(
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int MIN_INTERVAL    = 20
) (
  input  logic                     aclk,
  input  logic                     reset,
  axis_sample_pacer_if.slave       s_axis,
  axis_sample_pacer_if.master      m_axis,
`ifdef PACER_RUNTIME_INTERVAL_EN
  input  logic [15:0]              interval,
`endif
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  // FIFO storage: tlast packed above tdata so they always travel together.
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [PW-1:0]         count_cur;
  logic [PW-1:0]         count_next;
  logic                  s_ready_reg;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  state_t                state_reg;
  state_t                state_next;
  logic [15:0]           gap_reg;
  logic [15:0]           gap_next;
  logic [15:0]           interval_eff;

  logic                  out_valid_reg;
  logic                  out_valid_next;
  logic                  out_last_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  handshake;

`ifdef PACER_RUNTIME_INTERVAL_EN
  // A zero interval would never let the gap end, so it is promoted to 1.
  assign interval_eff = (interval == 16'd0) ? 16'd1 : interval;
`else
  localparam logic [15:0] MIN_IV = 16'(MIN_INTERVAL);
  assign interval_eff = MIN_IV;
`endif

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign count_cur  = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty = (count_cur == '0);
  assign fifo_count = count_cur;
  assign push       = s_axis.tvalid & s_ready_reg;
  assign handshake  = out_valid_reg & m_axis.tready;
  assign count_next = count_cur + (push ? PW'(1) : PW'(0)) - (pop ? PW'(1) : PW'(0));

  assign s_axis.tready = s_ready_reg;
  assign m_axis.tvalid = out_valid_reg;
  assign m_axis.tdata  = out_data_reg;
  assign m_axis.tlast  = out_last_reg;

  // FIFO write port; storage has no reset so it can map onto block RAM.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr_reg[FIFO_DEPTH_LOG2-1:0]] <= {s_axis.tlast, s_axis.tdata};
    end
  end

  // FIFO pointers and registered ready (computed from next occupancy, so
  // ready never depends combinationally on the pop decision's consumer).
  always_ff @(posedge aclk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      s_ready_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      s_ready_reg <= (count_next != PW'(DEPTH));
    end
  end

  // Pacing state and gap counter registers.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_reg <= IDLE;
      gap_reg   <= 16'd0;
    end else begin
      state_reg <= state_next;
      gap_reg   <= gap_next;
    end
  end

  // Next-state logic. The last gap cycle (counter at 1) doubles as the
  // IDLE pop check, so a waiting sample is popped on that edge and its
  // tvalid lands exactly MIN_INTERVAL clocks after the previous handshake.
  // With an interval of 1 the handshake cycle itself reloads the output.
  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && (gap_reg == 16'd0)) begin
          pop        = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (handshake) begin
          if (interval_eff == 16'd1) begin
            gap_next = 16'd0;
            if (!fifo_empty) begin
              pop        = 1'b1;
              state_next = PRESENT;
            end else begin
              state_next = IDLE;
            end
          end else begin
            gap_next   = interval_eff - 16'd1;
            state_next = GAP;
          end
        end
      end
      GAP: begin
        if (gap_reg <= 16'd1) begin
          gap_next = 16'd0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = PRESENT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          gap_next = gap_reg - 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
        gap_next   = 16'd0;
      end
    endcase
  end

  // Output decode: the beat is valid exactly while the FSM presents it.
  always_comb begin
    out_valid_next = (state_next == PRESENT);
  end

  // Output register: payload loads from the FIFO head on each pop and is
  // otherwise held stable while waiting for m_axis_tready.
  always_ff @(posedge aclk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      out_valid_reg <= out_valid_next;
      if (pop) begin
        {out_last_reg, out_data_reg} <= mem[rd_ptr_reg[FIFO_DEPTH_LOG2-1:0]];
      end
    end
  end

endmodule
